// File: rtl/mmcm_drp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mmcm_drp_pkg : DRP widths, FSM encodings, MMCM register addresses  |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
package mmcm_drp_pkg;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        TRX_IDLE = 2'd0,
        TRX_BUSY = 2'd1,
        TRX_DONE = 2'd2
    } trx_state_t;

    typedef enum logic [1:0] {
        LCK_RESET = 2'd0,
        LCK_COUNT = 2'd1,
        LCK_LOCKD = 2'd2
    } lock_state_t;

    // Registers the reconfiguration master touches
    localparam logic [ADDR_W-1:0] ADDR_CLKREG_FIRST = 7'h08;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG_LAST  = 7'h16;
    localparam logic [ADDR_W-1:0] ADDR_LOCK1        = 7'h18;
    localparam logic [ADDR_W-1:0] ADDR_LOCK2        = 7'h19;
    localparam logic [ADDR_W-1:0] ADDR_LOCK3        = 7'h1A;
    localparam logic [ADDR_W-1:0] ADDR_POWER        = 7'h28;
    localparam logic [ADDR_W-1:0] ADDR_FILT1        = 7'h4E;
    localparam logic [ADDR_W-1:0] ADDR_FILT2        = 7'h4F;

    function automatic logic is_mmcm_cfg_addr(input logic [ADDR_W-1:0] addr);
        return ((addr >= ADDR_CLKREG_FIRST) && (addr <= ADDR_CLKREG_LAST)) ||
               (addr == ADDR_LOCK1) || (addr == ADDR_LOCK2) || (addr == ADDR_LOCK3) ||
               (addr == ADDR_POWER) || (addr == ADDR_FILT1) || (addr == ADDR_FILT2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmcm_drp_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mmcm_drp_responder_if : DRP bus between master and MMCM responder  |
// | Revision              : 1.0                                        |
// +--------------------------------------------------------------------+
interface mmcm_drp_responder_if ();
    import mmcm_drp_pkg::*;

    logic              den;
    logic              dwe;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] di;
    logic [DATA_W-1:0] dout;
    logic              drdy;

    modport master (output den, output dwe, output daddr, output di,
                    input  dout, input drdy);
    modport slave  (input  den, input  dwe, input  daddr, input  di,
                    output dout, output drdy);
endinterface
`default_nettype wire

// File: rtl/mmcm_lock_model.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mmcm_lock_model : emulated MMCM LOCKED with programmable lock time |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module mmcm_lock_model
    import mmcm_drp_pkg::*;
#(
    parameter int LOCK_CYCLES = 64
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic mmcm_rst,
    output logic      locked
);

    localparam logic [15:0] C_LOCK_LAST = 16'(LOCK_CYCLES - 1);

    lock_state_t r_state;
    lock_state_t w_next;
    logic [15:0] r_cnt;

    // Reset counts as the first low sample of mmcm_rst when it is already released
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= mmcm_rst ? LCK_RESET : LCK_COUNT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (mmcm_rst) begin
            w_next = LCK_RESET;
        end else begin
            case (r_state)
                LCK_RESET: w_next = LCK_COUNT;
                LCK_COUNT: if (r_cnt == C_LOCK_LAST) w_next = LCK_LOCKD;
                LCK_LOCKD: w_next = LCK_LOCKD;
                default:   w_next = LCK_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || mmcm_rst || (r_state != LCK_COUNT)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_comb begin
        locked = (r_state == LCK_LOCKD);
    end

endmodule
`default_nettype wire

// File: rtl/mmcm_drp_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mmcm_drp_responder : DRP target emulating an MMCM register bank    |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module mmcm_drp_responder
    import mmcm_drp_pkg::*;
#(
    parameter int RD_LATENCY  = 4,
    parameter int LOCK_CYCLES = 64
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mmcm_drp_responder_if.slave drp,
    input  wire logic           mmcm_rst,
    output logic                locked,
    output logic [1:0]          err
);

    localparam logic [3:0] C_LAT_LOAD = 4'(RD_LATENCY - 1);

    trx_state_t        r_state;
    trx_state_t        w_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_di;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] r_bank [NUM_REGS];
    logic [1:0]        r_err;
    logic              w_accept;
    logic              w_collide;
    logic              w_finish;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= TRX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            TRX_IDLE: if (drp.den) w_next = TRX_BUSY;
            TRX_BUSY: if (r_cnt == 4'd0) w_next = TRX_DONE;
            TRX_DONE: w_next = TRX_IDLE;
            default:  w_next = TRX_IDLE;
        endcase
    end

    always_comb begin
        w_accept  = drp.den && (r_state == TRX_IDLE);
        w_collide = drp.den && (r_state != TRX_IDLE);
        w_finish  = (r_state == TRX_BUSY) && (r_cnt == 4'd0);
        drp.drdy  = (r_state == TRX_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_we   <= 1'b0;
            r_di   <= '0;
        end else if (w_accept) begin
            r_cnt  <= C_LAT_LOAD;
            r_addr <= drp.daddr;
            r_we   <= drp.dwe;
            r_di   <= drp.di;
        end else if ((r_state == TRX_BUSY) && (r_cnt != 4'd0)) begin
            r_cnt  <= r_cnt - 4'd1;
        end
    end

    // Bank update and read capture happen on the edge that enters DONE,
    // so DO is already valid while DRDY is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_bank[i] <= '0;
            end
            r_dout <= '0;
        end else if (w_finish) begin
            if (r_we) begin
                r_bank[r_addr] <= r_di;
            end else begin
                r_dout <= r_bank[r_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 2'b00;
        end else begin
            if (w_collide) r_err[0] <= 1'b1;
            if (w_accept && drp.dwe && !mmcm_rst) r_err[1] <= 1'b1;
        end
    end

    assign drp.dout = r_dout;
    assign err      = r_err;

    mmcm_lock_model #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock (
        .clk      (clk),
        .rst_n    (rst_n),
        .mmcm_rst (mmcm_rst),
        .locked   (locked)
    );

endmodule
`default_nettype wire

// File: doc/mmcm_drp_responder.md
# mmcm_drp_responder

Synthesizable DRP target that emulates the MMCM side of the dynamic-reconfiguration port. It answers DEN/DWE strobes from the DRP master with DO/DRDY after a fixed latency, holds a 128×16 configuration register bank, and models LOCKED: deasserted during MMCM reset, reasserted a programmable time after release. It serves as the closed-loop partner of the DRP master in the reconfiguration testbench and in the FPGA loopback build, where no real MMCM_ADV is wired to the master.

## Interface
Parameters:
- RD_LATENCY, 4, cycles from DEN acceptance to DRDY; legal range 1..15
- LOCK_CYCLES, 64, cycles after MMCM_RST falls until LOCKED rises; legal range 1..65535

Ports:
- CLK  in  1  single clock; DRP clock and logic clock are the same
- RST_N  in  1  reset, synchronous, active-low
- DEN  in  1  DRP enable strobe, one-cycle pulse
- DWE  in  1  write enable, sampled only with DEN
- DADDR  in  7  register address
- DI  in  16  write data
- MMCM_RST  in  1  MMCM reset from the master, active-high
- DO  out  16  read data
- DRDY  out  1  transaction-complete pulse
- LOCKED  out  1  emulated lock indication
- ERR  out  2  sticky errors: [0] DEN while busy, [1] write while MMCM_RST low

## Operation
- Register bank: REG[0..127], 16 bits each. All entries read 0x0000 after reset.
- Transaction FSM:
  - IDLE: on DEN=1, latch DADDR, DWE and DI, load the latency counter with RD_LATENCY-1, and go to BUSY.
  - BUSY: decrement the counter each cycle. When it reaches 0 and is seen in BUSY, go to DONE.
  - DONE: DRDY=1 for exactly one cycle, then return to IDLE.
- Read (DWE=0): DO=REG[addr] in the DRDY cycle. DO then holds that value until the next read's DRDY.
- Write (DWE=1): REG[addr] gets the latched DI on the DRDY clock edge. DO is unchanged.
- DEN outside IDLE, including the DONE cycle: the transaction is ignored and ERR[0] sets.
- DWE without DEN: ignored.
- Accepted write while MMCM_RST=0: the write is still performed and ERR[1] sets.
- ERR bits clear only on RST_N.
- Lock FSM:
  - RESET: entered while MMCM_RST=1. LOCKED=0 and the counter is cleared.
  - COUNT: entered when MMCM_RST=0. Count to LOCK_CYCLES, then go to LOCKD.
  - LOCKD: LOCKED=1.
  - MMCM_RST=1 in any state returns to RESET, and LOCKED falls on the next edge.
- The transaction and lock FSMs run independently. DRP access works regardless of LOCKED.

## Timing
- Reset values:
  - DO=0x0000, DRDY=0, LOCKED=0, ERR=2'b00.
  - Both FSMs enter their first state: transaction FSM to IDLE. Lock FSM to COUNT if MMCM_RST=0, otherwise RESET.
- Read/write latency: DEN sampled high at edge N gives DRDY=1 during cycle N+RD_LATENCY. Minimum spacing between accepted DENs is RD_LATENCY+1 cycles.
- Write visibility: a read accepted in or after the write's DRDY cycle returns the new value.
- Lock timing: MMCM_RST sampled low at edge M gives LOCKED=1 from cycle M+LOCK_CYCLES onward.
- Glitch: a one-cycle MMCM_RST pulse restarts the full LOCK_CYCLES count.
- RST_N low mid-transaction: the transaction is aborted with no DRDY and no write. REG is cleared.
- DEN and MMCM_RST rising in the same cycle: the transaction proceeds normally.

## Structure
- Shared package `mmcm_drp_pkg`:
  - DRP widths: ADDR_W=7, DATA_W=16.
  - State encodings for both FSMs.
  - The MMCM register address constants the master targets: 0x08..0x16, 0x18, 0x19, 0x1A, 0x28, 0x4E, 0x4F.
- One sub-module, `mmcm_lock_model`: the lock FSM plus its counter, with inputs CLK, RST_N and MMCM_RST and output LOCKED.
- Register bank and transaction FSM live in the top.

## Test plan
- Reset, then MMCM_RST=0 → LOCKED rises exactly 64 cycles later. Read DADDR=0x08 → DO=0x0000, with DRDY exactly 4 cycles after DEN.
- MMCM_RST=1, write 0x08 with DI=0x1041, then read 0x08 → DO=0x1041, ERR=00.
- Read-modify-write of 0x28 (mask 0x0000, set 0xFFFF) driven by the DRP master in loopback → a final read of 0x28 returns 0xFFFF. After the master releases MMCM_RST, LOCKED returns.
- Second DEN 2 cycles after a first one → exactly one DRDY, ERR[0]=1, REG unchanged by the second request.
- Write 0x4E=0x0800 with MMCM_RST=0 → write lands, ERR[1]=1.
- RST_N low at cycle 2 of a write to 0x16 → no DRDY, and 0x16 reads back 0x0000 afterwards.
- Sweep RD_LATENCY=1 and 15 → DRDY at N+1 and N+15 respectively.
